// File: rtl/pc_sequencer.sv
// Program-counter sequencer with a hardware return-address stack for the fetch stage.
// Build option PC_SEQ_RAS_WRAP_EN: a call on a full stack overwrites the oldest entry.
module pc_sequencer #(
  parameter int unsigned AW        = 8,
  parameter int unsigned RAS_DEPTH = 4,
  parameter logic [AW-1:0] RESET_VEC = '0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          br_take,
  input  logic          call,
  input  logic          ret,
  input  logic [AW-1:0] br_target,
  output logic [AW-1:0] pc,
  output logic [AW-1:0] link_top,
  output logic          ras_empty,
  output logic          ras_full,
  output logic          ras_err
);

  localparam int unsigned IW = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
  localparam int unsigned CW = $clog2(RAS_DEPTH + 1);
  localparam logic [IW-1:0] LastIdx = IW'(RAS_DEPTH - 1);
  localparam logic [CW-1:0] FullCnt = CW'(RAS_DEPTH);

  logic [AW-1:0] r_pc;
  logic [IW-1:0] r_top;
  logic [CW-1:0] r_cnt;
  logic          r_err;
  logic [AW-1:0] r_stack [RAS_DEPTH];

  logic [AW-1:0] w_pc_d;
  logic [AW-1:0] w_pc_inc;
  logic [IW-1:0] w_top_d;
  logic [IW-1:0] w_top_up;
  logic [IW-1:0] w_top_dn;
  logic [CW-1:0] w_cnt_d;
  logic          w_err_d;
  logic          w_push;
  logic          w_empty;
  logic          w_full;

  assign w_pc_inc = r_pc + AW'(1);
  assign w_top_up = (r_top == LastIdx) ? '0 : r_top + IW'(1);
  assign w_top_dn = (r_top == '0) ? LastIdx : r_top - IW'(1);
  assign w_empty  = (r_cnt == '0);
  assign w_full   = (r_cnt == FullCnt);

  always_comb begin
    w_pc_d  = r_pc;
    w_top_d = r_top;
    w_cnt_d = r_cnt;
    w_err_d = r_err;
    w_push  = 1'b0;
    if (en) begin
      if (ret) begin
        // A simultaneous call is dropped and flagged.
        if (call) w_err_d = 1'b1;
        if (w_empty) begin
          w_pc_d  = w_pc_inc;
          w_err_d = 1'b1;
        end else begin
          w_pc_d  = r_stack[r_top];
          w_top_d = w_top_dn;
          w_cnt_d = r_cnt - CW'(1);
        end
      end else if (call) begin
        w_pc_d = br_target;
        if (!w_full) begin
          w_push  = 1'b1;
          w_top_d = w_top_up;
          w_cnt_d = r_cnt + CW'(1);
        end else begin
`ifdef PC_SEQ_RAS_WRAP_EN
          // Circular overwrite: the slot after top holds the oldest entry.
          w_push  = 1'b1;
          w_top_d = w_top_up;
`else
          w_err_d = 1'b1;
`endif
        end
      end else if (br_take) begin
        w_pc_d = br_target;
      end else begin
        w_pc_d = w_pc_inc;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pc  <= RESET_VEC;
      r_top <= '0;
      r_cnt <= '0;
      r_err <= 1'b0;
    end else begin
      r_pc  <= w_pc_d;
      r_top <= w_top_d;
      r_cnt <= w_cnt_d;
      r_err <= w_err_d;
    end
  end

  // Stack contents need no reset; count gates every read.
  always_ff @(posedge clk) begin
    if (w_push) r_stack[w_top_up] <= w_pc_inc;
  end

  assign pc        = r_pc;
  assign link_top  = w_empty ? '0 : r_stack[r_top];
  assign ras_empty = w_empty;
  assign ras_full  = w_full;
  assign ras_err   = r_err;

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer (AW=8, RAS_DEPTH=4, RESET_VEC=0); honours PC_SEQ_RAS_WRAP_EN.
module tb_pc_sequencer;

  typedef struct packed {
    logic [7:0] pc;
    logic [7:0] link;
    logic       empty;
    logic       full;
    logic       err;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic       br_take = 1'b0;
  logic       call = 1'b0;
  logic       ret = 1'b0;
  logic [7:0] br_target = 8'h00;
  logic [7:0] pc;
  logic [7:0] link_top;
  logic       ras_empty;
  logic       ras_full;
  logic       ras_err;

  exp_t q[$];
  int   checks = 0;
  int   failures = 0;

  pc_sequencer #(
    .AW(8),
    .RAS_DEPTH(4),
    .RESET_VEC(8'h00)
  ) dut (
    .clk(clk),
    .rst(rst),
    .en(en),
    .br_take(br_take),
    .call(call),
    .ret(ret),
    .br_target(br_target),
    .pc(pc),
    .link_top(link_top),
    .ras_empty(ras_empty),
    .ras_full(ras_full),
    .ras_err(ras_err)
  );

  always #5 clk = ~clk;

  task automatic cmp(input string name, input logic [7:0] act, input logic [7:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic cmp_all(input string tag, input exp_t e);
    cmp({tag, " pc"}, pc, e.pc);
    cmp({tag, " link_top"}, link_top, e.link);
    cmp({tag, " ras_empty"}, {7'd0, ras_empty}, {7'd0, e.empty});
    cmp({tag, " ras_full"}, {7'd0, ras_full}, {7'd0, e.full});
    cmp({tag, " ras_err"}, {7'd0, ras_err}, {7'd0, e.err});
  endtask

  // Monitor: one expectation per clock edge while the queue holds any.
  always @(posedge clk) begin
    #1;
    if (q.size() != 0) cmp_all("step", q.pop_front());
  end

  task automatic drive(input logic e, input logic b, input logic c, input logic r,
                       input logic [7:0] t, input logic [7:0] xpc, input logic [7:0] xlink,
                       input logic xe, input logic xf, input logic xerr);
    exp_t x;
    en = e; br_take = b; call = c; ret = r; br_target = t;
    x.pc = xpc; x.link = xlink; x.empty = xe; x.full = xf; x.err = xerr;
    q.push_back(x);
  endtask

  task automatic step(input logic e, input logic b, input logic c, input logic r,
                      input logic [7:0] t, input logic [7:0] xpc, input logic [7:0] xlink,
                      input logic xe, input logic xf, input logic xerr);
    @(negedge clk);
    drive(e, b, c, r, t, xpc, xlink, xe, xf, xerr);
  endtask

  // Async reset mid-cycle, check immediately, release so the first edge gives pc=1.
  task automatic do_reset();
    exp_t z;
    @(posedge clk);
    #3;
    rst = 1'b1;
    en = 1'b0; br_take = 1'b0; call = 1'b0; ret = 1'b0;
    #1;
    z = '{pc: 8'h00, link: 8'h00, empty: 1'b1, full: 1'b0, err: 1'b0};
    cmp_all("reset", z);
    @(negedge clk);
    rst = 1'b0;
    drive(1, 0, 0, 0, 8'h00, 8'h01, 8'h00, 1, 0, 0);
  endtask

  initial begin
    #1;
    cmp_all("por", '{pc: 8'h00, link: 8'h00, empty: 1'b1, full: 1'b0, err: 1'b0});
    @(negedge clk);
    rst = 1'b0;
    drive(1, 0, 0, 0, 8'h00, 8'h01, 8'h00, 1, 0, 0);

    // Build pc=0x37 with two entries, then reset mid-run
    step(1, 1, 0, 0, 8'h30, 8'h30, 8'h00, 1, 0, 0);
    step(1, 0, 1, 0, 8'h34, 8'h34, 8'h31, 0, 0, 0);
    step(1, 0, 1, 0, 8'h36, 8'h36, 8'h35, 0, 0, 0);
    step(1, 0, 0, 0, 8'h00, 8'h37, 8'h35, 0, 0, 0);
    do_reset();

    // PC wrap
    step(1, 1, 0, 0, 8'hFE, 8'hFE, 8'h00, 1, 0, 0);
    step(1, 0, 0, 0, 8'h00, 8'hFF, 8'h00, 1, 0, 0);
    step(1, 0, 0, 0, 8'h00, 8'h00, 8'h00, 1, 0, 0);

    // Simple call/return
    step(1, 1, 0, 0, 8'h10, 8'h10, 8'h00, 1, 0, 0);
    step(1, 0, 1, 0, 8'h40, 8'h40, 8'h11, 0, 0, 0);
    step(1, 0, 0, 1, 8'h00, 8'h11, 8'h00, 1, 0, 0);

    // Five nested calls, then five returns
    step(1, 1, 0, 0, 8'h00, 8'h00, 8'h00, 1, 0, 0);
    step(1, 0, 1, 0, 8'h20, 8'h20, 8'h01, 0, 0, 0);
    step(1, 0, 1, 0, 8'h21, 8'h21, 8'h21, 0, 0, 0);
    step(1, 0, 1, 0, 8'h22, 8'h22, 8'h22, 0, 0, 0);
    step(1, 0, 1, 0, 8'h23, 8'h23, 8'h23, 0, 1, 0);
`ifdef PC_SEQ_RAS_WRAP_EN
    step(1, 0, 1, 0, 8'h24, 8'h24, 8'h24, 0, 1, 0);
    step(1, 0, 0, 1, 8'h00, 8'h24, 8'h23, 0, 0, 0);
    step(1, 0, 0, 1, 8'h00, 8'h23, 8'h22, 0, 0, 0);
    step(1, 0, 0, 1, 8'h00, 8'h22, 8'h21, 0, 0, 0);
    step(1, 0, 0, 1, 8'h00, 8'h21, 8'h00, 1, 0, 0);
    step(1, 0, 0, 1, 8'h00, 8'h22, 8'h00, 1, 0, 1);
`else
    step(1, 0, 1, 0, 8'h24, 8'h24, 8'h23, 0, 1, 1);
    step(1, 0, 0, 1, 8'h00, 8'h23, 8'h22, 0, 0, 1);
    step(1, 0, 0, 1, 8'h00, 8'h22, 8'h21, 0, 0, 1);
    step(1, 0, 0, 1, 8'h00, 8'h21, 8'h01, 0, 0, 1);
    step(1, 0, 0, 1, 8'h00, 8'h01, 8'h00, 1, 0, 1);
    step(1, 0, 0, 1, 8'h00, 8'h02, 8'h00, 1, 0, 1);
`endif
    do_reset();

    // Underflow at pc=0x20
    step(1, 1, 0, 0, 8'h20, 8'h20, 8'h00, 1, 0, 0);
    step(1, 0, 0, 1, 8'h00, 8'h21, 8'h00, 1, 0, 1);
    do_reset();

    // call+ret conflict with top=0x55
    step(1, 1, 0, 0, 8'h54, 8'h54, 8'h00, 1, 0, 0);
    step(1, 0, 1, 0, 8'h60, 8'h60, 8'h55, 0, 0, 0);
    step(1, 0, 1, 1, 8'h70, 8'h55, 8'h00, 1, 0, 1);

    // Stall with every control asserted, then branch
    step(1, 0, 1, 0, 8'h80, 8'h80, 8'h56, 0, 0, 1);
    step(0, 1, 1, 1, 8'h99, 8'h80, 8'h56, 0, 0, 1);
    step(0, 1, 1, 1, 8'h99, 8'h80, 8'h56, 0, 0, 1);
    step(0, 1, 1, 1, 8'h99, 8'h80, 8'h56, 0, 0, 1);
    step(1, 1, 0, 0, 8'h99, 8'h99, 8'h56, 0, 0, 1);

    @(negedge clk);
    en = 1'b0; br_take = 1'b0; call = 1'b0; ret = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL drain: %0d expectations left, expected 0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
